lzd_pipe: RTL and testbench

LZD_PIPE -- requirements
Module: lzd_pipe

---
 rtl/lzd_pkg.sv | 20 ++
 rtl/lzc_tree.sv | 47 ++++
 rtl/lzd_pipe.sv | 94 +++++++++
 tb/tb_lzd_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lzd_pkg.sv
// Shared sizing helpers and stage-1 payload type for the leading-zero pipeline.
package lzd_pkg;

  // The payload carries a wide difference field; each user keeps its own W low bits.
  localparam int PAY_W = 64;

  function automatic int calc_w(input int m, input int extra, input int sgn);
    return m + extra - sgn;
  endfunction

  function automatic int calc_cw(input int w);
    return $clog2(w + 1);
  endfunction

  typedef struct packed {
    logic [PAY_W-1:0] diff;
    logic             borrow;
  } s1_pay_t;

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a binary tree of depth log2(W).
// The input is zero-padded on the right to a power of two. Padding bits never
// change the count of a non-zero vector. An all-zero vector reports W.
module lzc_tree
  import lzd_pkg::*;
#(
  parameter int W = 29,
  localparam int CW = calc_cw(W),
  localparam int L  = $clog2(W),
  localparam int P  = 1 << L
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [P-1:0] x;

  if (P > W) begin : g_pad
    assign x = {vec, {(P-W){1'b0}}};
  end else begin : g_nopad
    assign x = vec;
  end

  // Each level merges pairs: take the left count if the left half has a one,
  // otherwise the full left width plus the right count.
  for (genvar k = 1; k <= L; k++) begin : lvl
    localparam int N = P >> k;
    logic [N-1:0]        v;
    logic [N-1:0][k-1:0] c;
    for (genvar i = 0; i < N; i++) begin : node
      if (k == 1) begin : leaf
        assign v[i] = x[2*i+1] | x[2*i];
        assign c[i] = ~x[2*i+1];
      end else begin : inner
        logic vl;
        assign vl   = lvl[k-1].v[2*i+1];
        assign v[i] = vl | lvl[k-1].v[2*i];
        assign c[i] = vl ? {1'b0, lvl[k-1].c[2*i+1]} : {1'b1, lvl[k-1].c[2*i]};
      end
    end
  end

  assign zero = ~lvl[L].v[0];
  assign cnt  = zero ? CW'(W) : CW'(lvl[L].c[0]);

endmodule

// File: rtl/lzd_pipe.sv
// Two-stage subtract + leading-zero-count pipeline with valid/ready handshakes.
// S1 registers diff/borrow. S2 registers the count, the zero flag and the
// passed-through diff/borrow.
// Optional LZD_PIPE_NORM_EN adds a registered normalized output (diff << lz_cnt).
module lzd_pipe
  import lzd_pkg::*;
#(
  parameter int M          = 23,
  parameter int EXTRA_BITS = 7,
  parameter int SIGN_BITS  = 1,
  localparam int W  = calc_w(M, EXTRA_BITS, SIGN_BITS),
  localparam int CW = calc_cw(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] lz_cnt,
  output logic [W-1:0]  diff,
  output logic          borrow,
  output logic          zero
`ifdef LZD_PIPE_NORM_EN
  , output logic [W-1:0] norm
`endif
);

  logic          s1_valid;
  s1_pay_t       s1_q;
  logic          s1_adv, s2_adv;
  logic [W:0]    sub;
  logic [W-1:0]  s1_diff;
  logic [CW-1:0] cnt_c;
  logic          zero_c;
  logic          s1_unused;

  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign sub       = {1'b0, a} - {1'b0, b};
  assign s1_diff   = s1_q.diff[W-1:0];
  assign s1_unused = ^s1_q.diff;

  lzc_tree #(.W(W)) u_lzc (
    .vec  (s1_diff),
    .cnt  (cnt_c),
    .zero (zero_c)
  );

`ifdef LZD_PIPE_NORM_EN
  logic [W-1:0] norm_c;
  assign norm_c = zero_c ? '0 : (s1_diff << cnt_c);
`endif

  // S1: capture the difference whenever the stage is free to move.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= '{diff: PAY_W'(sub[W-1:0]), borrow: sub[W]};
    end
  end

  // S2: register the count. The outputs are frozen while the result is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      lz_cnt    <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
`ifdef LZD_PIPE_NORM_EN
      norm      <= '0;
`endif
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        lz_cnt <= cnt_c;
        diff   <= s1_diff;
        borrow <= s1_q.borrow;
        zero   <= zero_c;
`ifdef LZD_PIPE_NORM_EN
        norm   <= norm_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lzd_pipe.sv
// Scoreboard bench for lzd_pipe (default parameters, W=29).
// Accepted inputs push their expected result. An independent monitor pops and
// compares each emitted result.
module tb_lzd_pipe;
  localparam int W  = 29;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, diff;
  logic [CW-1:0] lz_cnt;
  logic          borrow, zero;
`ifdef LZD_PIPE_NORM_EN
  logic [W-1:0]  norm;
`endif

  lzd_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .lz_cnt(lz_cnt), .diff(diff), .borrow(borrow), .zero(zero)
`ifdef LZD_PIPE_NORM_EN
    , .norm(norm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  diff;
    logic [CW-1:0] lz;
    logic          borrow;
    logic          zero;
    logic [W-1:0]  norm;
  } res_t;

  res_t q[$];
  res_t cur_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model for the random phase: linear scan for the top set bit.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t       r;
    logic [W:0] s;
    s        = {1'b0, x} - {1'b0, y};
    r.diff   = s[W-1:0];
    r.borrow = s[W];
    r.zero   = (r.diff == '0);
    r.lz     = CW'(W);
    r.norm   = '0;
    for (int i = 0; i < W; i++) if (r.diff[i]) r.lz = CW'(W - 1 - i);
    if (!r.zero) r.norm = r.diff << r.lz;
    return r;
  endfunction

  // Monitor: pop/compare on emit, then record this cycle's accept.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got diff 0x%0h lz %0d, expected no result", diff, lz_cnt);
        end else begin
          e = q.pop_front();
          chk("result{diff,lz,borrow,zero}", 64'({diff, lz_cnt, borrow, zero}),
              64'({e.diff, e.lz, e.borrow, e.zero}));
`ifdef LZD_PIPE_NORM_EN
          chk("norm", 64'(norm), 64'(e.norm));
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  // Present one operand pair and hold it until accepted (bounded wait).
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input res_t e);
    logic acc;
    a = va; b = vb; cur_exp = e; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (t == 199) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: in_ready stayed 0, expected an accept within 200 cycles");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [W-1:0] da [7] = '{29'h10, 29'd5, 29'd0, 29'h1FFFFFFF, 29'h100, 29'h08000000, 29'h3000};
  logic [W-1:0] db [7] = '{29'h0F, 29'd5, 29'd1, 29'h0,        29'h0,   29'h0,        29'h1000};
  res_t dexp [7] = '{
    '{29'h1,        5'd28, 1'b0, 1'b0, 29'h10000000},
    '{29'h0,        5'd29, 1'b0, 1'b1, 29'h0},
    '{29'h1FFFFFFF, 5'd0,  1'b1, 1'b0, 29'h1FFFFFFF},
    '{29'h1FFFFFFF, 5'd0,  1'b0, 1'b0, 29'h1FFFFFFF},
    '{29'h100,      5'd20, 1'b0, 1'b0, 29'h10000000},
    '{29'h08000000, 5'd1,  1'b0, 1'b0, 29'h10000000},
    '{29'h2000,     5'd15, 1'b0, 1'b0, 29'h10000000}};

  logic [W-1:0] sa [4] = '{29'h20, 29'd3, 29'h1000, 29'h40000};
  logic [W-1:0] sb [4] = '{29'h01, 29'd7, 29'h1000, 29'h0};
  res_t sexp [4] = '{
    '{29'h1F,       5'd24, 1'b0, 1'b0, 29'h1F000000},
    '{29'h1FFFFFFC, 5'd0,  1'b1, 1'b0, 29'h1FFFFFFC},
    '{29'h0,        5'd29, 1'b0, 1'b1, 29'h0},
    '{29'h40000,    5'd10, 1'b0, 1'b0, 29'h10000000}};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1000000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cur_exp = '0;
    tick(2);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'({lz_cnt, diff, borrow, zero}), 64'd0);
    rst = 1'b0;
    tick(1);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed vectors; the first also checks the two-cycle latency.
    send(da[0], db[0], dexp[0]);
    chk("latency_cycle1_out_valid", 64'(out_valid), 64'd0);
    tick(1);
    chk("latency_cycle2_out_valid", 64'(out_valid), 64'd1);
    for (int i = 1; i < 7; i++) send(da[i], db[i], dexp[i]);
    tick(4);

    // Backpressure: two accepts fill the pipe, then in_ready drops and outputs hold.
    out_ready = 1'b0;
    send(sa[0], sb[0], sexp[0]);
    send(sa[1], sb[1], sexp[1]);
    a = sa[2]; b = sb[2]; cur_exp = sexp[2]; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_held_output", 64'({out_valid, diff, lz_cnt}), 64'({1'b1, sexp[0].diff, sexp[0].lz}));
      tick(1);
    end
    out_ready = 1'b1;
    send(sa[2], sb[2], sexp[2]);
    send(sa[3], sb[3], sexp[3]);
    tick(4);

    // Reset with both stages full: nothing in flight may ever emerge.
    out_ready = 1'b0;
    send(da[0], db[0], dexp[0]);
    send(da[1], db[1], dexp[1]);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick(5);
    chk("flush_still_idle", 64'(out_valid), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra - W'($urandom_range(0, 255));
        default: rb = W'($urandom);
      endcase
      a = ra; b = rb; cur_exp = model(ra, rb);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(10);
    chk("drain_pending_results", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
